// File: rtl/cdb_broadcast_arbiter_if.sv
// Result-bus bundle between functional units, the CDB arbiter and
// the reservation-station search ports.
interface cdb_broadcast_arbiter_if #(
  parameter int FU_PORTS      = 4,
  parameter int SEARCH_PORTS  = 2,
  parameter int TW            = 4,
  parameter int OPERAND_WIDTH = 32
);
  logic [FU_PORTS-1:0]                        fu_valid;
  logic [FU_PORTS-1:0]                        fu_ready;
  logic [FU_PORTS-1:0][TW-1:0]                fu_tag;
  logic [FU_PORTS-1:0][OPERAND_WIDTH-1:0]     fu_data;
  logic                                       flush;
  logic [SEARCH_PORTS-1:0]                    search_valid;
  logic [SEARCH_PORTS-1:0][TW-1:0]            search_tags;
  logic [SEARCH_PORTS-1:0][OPERAND_WIDTH-1:0] search_data;

  modport master (
    input  fu_valid, fu_tag, fu_data, flush,
    output fu_ready, search_valid, search_tags, search_data
  );

  modport slave (
    output fu_valid, fu_tag, fu_data, flush,
    input  fu_ready, search_valid, search_tags, search_data
  );
endinterface

// File: rtl/cdb_broadcast_arbiter.sv
// CDB producer: per-FU result FIFOs, round-robin pick of SEARCH_PORTS
// results per cycle, registered broadcast. Option: CDB_BYPASS_EN.
module cdb_broadcast_arbiter #(
  parameter int FU_PORTS      = 4,
  parameter int SEARCH_PORTS  = 2,
  parameter int ROB_DEPTH     = 16,
  parameter int OPERAND_WIDTH = 32,
  parameter int BUF_DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  cdb_broadcast_arbiter_if.master      bus
);

  localparam int TW = $clog2(ROB_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int IW = (FU_PORTS > 1) ? $clog2(FU_PORTS) : 1;

  logic [TW-1:0]            mtag_q  [FU_PORTS][BUF_DEPTH];
  logic [OPERAND_WIDTH-1:0] mdata_q [FU_PORTS][BUF_DEPTH];
  logic [PW-1:0]            head_q  [FU_PORTS];
  logic [PW-1:0]            tail_q  [FU_PORTS];
  logic [CW-1:0]            cnt_q   [FU_PORTS];

  logic [IW-1:0] rr_q, rr_d;

  logic [SEARCH_PORTS-1:0]                    sv_q, sv_d;
  logic [SEARCH_PORTS-1:0][TW-1:0]            st_q, st_d;
  logic [SEARCH_PORTS-1:0][OPERAND_WIDTH-1:0] sd_q, sd_d;

  logic [FU_PORTS-1:0] ready;
  logic [FU_PORTS-1:0] nonempty;
  logic [FU_PORTS-1:0] push;
  logic [FU_PORTS-1:0] pop;
  logic [FU_PORTS-1:0] byp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Ready is from the registered count only: a full FIFO
  // stays not-ready during the cycle it is popped.
  always_comb begin
    for (int i = 0; i < FU_PORTS; i++) begin
      ready[i]    = cnt_q[i] < CW'(BUF_DEPTH);
      nonempty[i] = cnt_q[i] != '0;
      push[i]     = bus.fu_valid[i] & ready[i] & ~byp[i];
    end
  end

  assign bus.fu_ready     = ready;
  assign bus.search_valid = sv_q;
  assign bus.search_tags  = st_q;
  assign bus.search_data  = sd_q;

  always_comb begin
    int n;
    int idx;
    pop  = '0;
    byp  = '0;
    sv_d = '0;
    st_d = st_q;
    sd_d = sd_q;
    rr_d = rr_q;
    n    = 0;
    idx  = 0;
    for (int s = 0; s < FU_PORTS; s++) begin
      idx = (int'(rr_q) + s) % FU_PORTS;
      if (n < SEARCH_PORTS) begin
        if (nonempty[idx]) begin
          pop[idx] = 1'b1;
          sv_d[n]  = 1'b1;
          st_d[n]  = mtag_q[idx][head_q[idx]];
          sd_d[n]  = mdata_q[idx][head_q[idx]];
          rr_d     = IW'((idx + 1) % FU_PORTS);
          n        = n + 1;
        end
`ifdef CDB_BYPASS_EN
        else if (bus.fu_valid[idx]) begin
          byp[idx] = 1'b1;
          sv_d[n]  = 1'b1;
          st_d[n]  = bus.fu_tag[idx];
          sd_d[n]  = bus.fu_data[idx];
          rr_d     = IW'((idx + 1) % FU_PORTS);
          n        = n + 1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      sv_q <= '0;
      st_q <= '0;
      sd_q <= '0;
      for (int i = 0; i < FU_PORTS; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
        for (int j = 0; j < BUF_DEPTH; j++) begin
          mtag_q[i][j]  <= '0;
          mdata_q[i][j] <= '0;
        end
      end
    end else if (bus.flush) begin
      sv_q <= '0;
      for (int i = 0; i < FU_PORTS; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      rr_q <= rr_d;
      sv_q <= sv_d;
      st_q <= st_d;
      sd_q <= sd_d;
      for (int i = 0; i < FU_PORTS; i++) begin
        if (push[i]) begin
          mtag_q[i][tail_q[i]]  <= bus.fu_tag[i];
          mdata_q[i][tail_q[i]] <= bus.fu_data[i];
          tail_q[i]             <= ptr_inc(tail_q[i]);
        end
        if (pop[i]) begin
          head_q[i] <= ptr_inc(head_q[i]);
        end
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end else if (!push[i] && pop[i]) begin
          cnt_q[i] <= cnt_q[i] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed bench for cdb_broadcast_arbiter (default build, no bypass).
// Expected values are hand-derived per scenario.
module tb_cdb_broadcast_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks_n = 0;
  int   fail_n   = 0;

  always #5 clk = ~clk;

  cdb_broadcast_arbiter_if #(
    .FU_PORTS(4), .SEARCH_PORTS(2), .TW(4), .OPERAND_WIDTH(32)
  ) bus ();

  cdb_broadcast_arbiter #(
    .FU_PORTS(4), .SEARCH_PORTS(2), .ROB_DEPTH(16),
    .OPERAND_WIDTH(32), .BUF_DEPTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.fu_valid = '0;
    bus.flush    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.fu_tag[i]  = '0;
      bus.fu_data[i] = '0;
    end
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_all(input logic [3:0] v);
    bus.fu_valid = v;
    for (int i = 0; i < 4; i++) begin
      bus.fu_tag[i]  = 4'(i + 1);
      bus.fu_data[i] = 32'h1000 + 32'(i);
    end
  endtask

  initial begin
    idle_in();
    do_reset();

    // 1: reset state, then reset mid-burst
    chk("rst_valid", 64'(bus.search_valid), 64'h0);
    chk("rst_ready", 64'(bus.fu_ready), 64'hF);
    chk("rst_tags", 64'(bus.search_tags), 64'h0);
    chk("rst_data0", 64'(bus.search_data[0]), 64'h0);
    drive_all(4'b1111);
    tick();
    tick();
    chk("burst_valid", 64'(bus.search_valid), 64'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.search_valid), 64'h0);
    chk("midrst_ready", 64'(bus.fu_ready), 64'hF);
    idle_in();
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_v1", 64'(bus.search_valid), 64'h0);
    tick();
    chk("postrst_v2", 64'(bus.search_valid), 64'h0);

    // 2: single result, two-edge latency
    do_reset();
    bus.fu_valid   = 4'b0100;
    bus.fu_tag[2]  = 4'd5;
    bus.fu_data[2] = 32'hDEADBEEF;
    tick();
    idle_in();
    chk("single_e0_valid", 64'(bus.search_valid), 64'h0);
    tick();
    chk("single_valid", 64'(bus.search_valid), 64'h1);
    chk("single_tag", 64'(bus.search_tags[0]), 64'h5);
    chk("single_data", 64'(bus.search_data[0]), 64'hDEADBEEF);
    tick();
    chk("single_once", 64'(bus.search_valid), 64'h0);

    // 3: contention from rr=0
    do_reset();
    drive_all(4'b1111);
    tick();
    idle_in();
    tick();
    chk("cont1_valid", 64'(bus.search_valid), 64'h3);
    chk("cont1_t0", 64'(bus.search_tags[0]), 64'h1);
    chk("cont1_t1", 64'(bus.search_tags[1]), 64'h2);
    tick();
    chk("cont2_valid", 64'(bus.search_valid), 64'h3);
    chk("cont2_t0", 64'(bus.search_tags[0]), 64'h3);
    chk("cont2_t1", 64'(bus.search_tags[1]), 64'h4);
    chk("cont2_d1", 64'(bus.search_data[1]), 64'h1003);
    tick();
    chk("cont3_valid", 64'(bus.search_valid), 64'h0);
    drive_all(4'b1111);
    tick();
    idle_in();
    tick();
    chk("rr_back0_t0", 64'(bus.search_tags[0]), 64'h1);
    chk("rr_back0_t1", 64'(bus.search_tags[1]), 64'h2);

    // 4: fairness, FU0/FU1 streaming, FU3 once
    do_reset();
    bus.fu_valid  = 4'b1011;
    bus.fu_tag[0] = 4'd6;
    bus.fu_tag[1] = 4'd7;
    bus.fu_tag[3] = 4'd9;
    tick();
    bus.fu_valid = 4'b0011;
    tick();
    chk("fair1_t0", 64'(bus.search_tags[0]), 64'h6);
    chk("fair1_t1", 64'(bus.search_tags[1]), 64'h7);
    tick();
    chk("fair2_valid", 64'(bus.search_valid), 64'h3);
    chk("fair2_fu3", 64'(bus.search_tags[0]), 64'h9);
    chk("fair2_fu0", 64'(bus.search_tags[1]), 64'h6);

    // 5: backpressure, FU0 tags 1..3 while FU1..3 saturate
    do_reset();
    bus.fu_valid  = 4'b1111;
    bus.fu_tag[0] = 4'd1;
    bus.fu_tag[1] = 4'd8;
    bus.fu_tag[2] = 4'd9;
    bus.fu_tag[3] = 4'd10;
    tick();
    bus.fu_tag[0] = 4'd2;
    tick();
    chk("bp_e1_t0", 64'(bus.search_tags[0]), 64'h1);
    chk("bp_e1_t1", 64'(bus.search_tags[1]), 64'h8);
    chk("bp_e1_ready", 64'(bus.fu_ready), 64'h3);
    bus.fu_tag[0] = 4'd3;
    tick();
    bus.fu_valid[0] = 1'b0;
    chk("bp_e2_ready0", 64'(bus.fu_ready[0]), 64'h0);
    chk("bp_e2_t0", 64'(bus.search_tags[0]), 64'h9);
    chk("bp_e2_t1", 64'(bus.search_tags[1]), 64'hA);
    tick();
    chk("bp_e3_t0", 64'(bus.search_tags[0]), 64'h2);
    chk("bp_e3_t1", 64'(bus.search_tags[1]), 64'h8);
    tick();
    chk("bp_e4_t0", 64'(bus.search_tags[0]), 64'h9);
    chk("bp_e4_t1", 64'(bus.search_tags[1]), 64'hA);
    tick();
    chk("bp_e5_t0", 64'(bus.search_tags[0]), 64'h3);
    chk("bp_e5_valid", 64'(bus.search_valid), 64'h3);

    // 6: flush drops buffered results
    do_reset();
    drive_all(4'b0111);
    tick();
    idle_in();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_valid", 64'(bus.search_valid), 64'h0);
    chk("flush_ready", 64'(bus.fu_ready), 64'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_quiet", 64'(bus.search_valid), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
    $finish;
  end

endmodule
